mux_pipe_n: RTL and testbench
=============================

Name: mux_pipe_n

Overview:
- Parametrised successor to the datapath 2:1 select mux: N-input, WIDTH-bit selector with a registered output stage and valid/ready handshake.
- Used where a select path must be cut by a pipeline register, e.g. writeback select or ALU operand select in the pipelined core.
- A 2-entry skid buffer allows full throughput with a fully registered in_ready.
- Out-of-range selects are flagged and produce zero data.

Parameters:
- WIDTH, 64, data width of each input and of the output.
- NUM_INPUTS, 4, number of selectable inputs; legal range 2..16.
- SEL_W, clog2(NUM_INPUTS) (minimum 1), select width; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  NUM_INPUTS*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  input index; sampled together with in_data.
- in_valid  in  1  upstream offers the {in_data, in_sel} beat.
- in_ready  out  1  block can accept a beat; registered.
- out_data  out  WIDTH  selected data; registered.
- out_sel_err  out  1  beat on out_data came from an in_sel >= NUM_INPUTS.
- out_valid  out  1  out_data/out_sel_err are valid.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset (async, active-high): state EMPTY, out_valid=0, in_ready=1, out_data=0, out_sel_err=0, skid contents=0.
- Accept: accept = in_valid & in_ready. Emit: emit = out_valid & out_ready.
- Select: sel_data = input[in_sel] if in_sel < NUM_INPUTS, else all zeros with sel_err=1.
  - The select is evaluated combinationally at input. Only {sel_data, sel_err} is stored.
- Latency: a beat accepted in cycle t appears on out_data in cycle t+1 if the main register is free or emits in cycle t.
- Storage: main register (drives outputs) and skid register. The state machine has three states:
  - EMPTY: accept -> main <= beat, go to ONE.
  - ONE, accept & emit: main <= beat, stay in ONE.
  - ONE, accept & !emit: skid <= beat, go to TWO, in_ready <= 0.
  - ONE, !accept & emit: go to EMPTY.
  - ONE, neither: hold.
  - TWO, emit: main <= skid, go to ONE, in_ready <= 1.
  - TWO, otherwise: hold. in_ready=0, so no accept is possible.
- out_valid = (state != EMPTY). in_ready = (state != TWO), taken directly from a flop.
- Ordering: beats leave in strict acceptance order. No beat is dropped or duplicated.
- Hold rule: while out_valid & !out_ready, out_data and out_sel_err are held stable.
- Backpressure: in_data/in_sel changes while in_ready=0 are ignored.
- Simultaneous accept and emit in EMPTY cannot occur, because out_valid=0.
- Reset mid-operation: all buffered beats are discarded immediately (async). Outputs reach their reset values without waiting for a clock edge.
- sel_err has no side effect beyond out_sel_err. Flow control is unchanged.

Decomposition:
- Shared package mux_pkg holds:
  - state encoding constants: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2; 2'd3 is illegal and recovers to ST_EMPTY.
  - clog2 function used to derive SEL_W.
  - Default WIDTH constant of 64, matching the core datapath width.
- One sub-module, skid_buffer: WIDTH+1 bit payload, generic valid/ready 2-entry skid.
  - mux_pipe_n = combinational N-way select + skid_buffer instance.

Test Plan (WIDTH=64, NUM_INPUTS=4 unless noted):
- Reset, then idle: out_valid=0, in_ready=1, out_data=0; assert reset mid-stream with 2 beats buffered -> out_valid drops immediately, no old beat emitted after release.
- Streaming, out_ready=1: inputs 0x11,0x22,0x33,0x44, sel 2 for 4 cycles, in_valid=1 -> out_data=0x33 from cycle t+1, one beat per cycle, in_ready stays 1.
- Backpressure: sel=0 beat (0xAAAA) then sel=3 beat (0xBBBB) with out_ready=0 -> state TWO, in_ready=0 next cycle, out_data holds 0xAAAA; release out_ready -> 0xAAAA then 0xBBBB, in_ready back to 1 after first emit.
- Out-of-range: NUM_INPUTS=3, SEL_W=2, in_sel=3 -> out_data=0, out_sel_err=1 for exactly that beat; next beat sel=1 -> out_sel_err=0.
- Random valid/ready stress: 10,000 beats, random sel/data, ~50% out_ready duty -> scoreboard order and value exact, no loss or duplication, out_data stable whenever out_valid & !out_ready.
- Parameter sweep: NUM_INPUTS=2 (SEL_W=1) and 16, WIDTH=32 -> every index k returns input k.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined N-way select mux: FSM state
// encoding, select-width helper and the default core datapath width.
package mux_pkg;

  // Core datapath width used when no override is given.
  localparam int DEFAULT_WIDTH = 64;

  // Occupancy of the 2-entry skid buffer. 2'd3 is illegal and recovers to ST_EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Ceiling log2 with a floor of 1, so a 2-input mux still gets a 1-bit select.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry skid buffer. The main register drives the output and the
// skid register catches the one beat that arrives while the output stalls.
// This lets in_ready come straight from a flop without losing throughput.
//
// Handshake: a beat moves when valid and ready are both high at a rising
// edge. The producer holds its payload while valid is high and ready is
// low. The buffer never withdraws out_valid until the beat is taken, and it
// holds out_data stable while it waits.
module skid_buffer import mux_pkg::*; #(
  parameter int W = DEFAULT_WIDTH + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output state_e       state_o
);

  state_e       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept;
  logic         emit;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = main_q;
  assign state_o     = state_q;

  assign accept = in_valid_i & in_ready_q;
  assign emit   = out_valid_o & out_ready_i;

  // Next-state logic: the occupancy FSM plus the main and skid register loads.
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    in_ready_d = in_ready_q;
    case (state_q)
      ST_EMPTY: begin
        in_ready_d = 1'b1;
        if (accept) begin
          main_d  = in_data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && emit) begin
          main_d = in_data_i;
        end else if (accept) begin
          skid_d     = in_data_i;
          state_d    = ST_TWO;
          in_ready_d = 1'b0;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain path is possible.
        if (emit) begin
          main_d     = skid_q;
          state_d    = ST_ONE;
          in_ready_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_EMPTY;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and storage registers. Reset discards all buffered beats at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// N-input select mux with a registered, valid/ready-handshaked output.
// The select is resolved at the input. Only {data, sel_err} is buffered.
// An out-of-range select produces zero data and raises out_sel_err for that beat.
module mux_pipe_n import mux_pkg::*; #(
  parameter  int WIDTH      = DEFAULT_WIDTH,
  parameter  int NUM_INPUTS = 4,
  localparam int SEL_W      = clog2(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_sel_err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  dbg_state
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  state_e           buf_state;

  // Input-side select. An index with no matching input falls through to zero data and an error flag.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (int'(in_sel) == k) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  skid_buffer #(
    .W (WIDTH + 1)
  ) u_skid (
    .clk_i       (clk),
    .rst_i       (reset),
    .in_data_i   ({sel_err, sel_data}),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  ({out_sel_err, out_data}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .state_o     (buf_state)
  );

  assign dbg_state = buf_state;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: a main 64x4 instance with a queue model, and side
// instances for out-of-range select (N=3) and the 32-bit N=2 / N=16 sweep.
module tb_mux_pipe_n;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT (WIDTH=64, N=4) ----------------
  logic [255:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid, in_ready, out_valid, out_ready, out_sel_err;
  logic [63:0]  out_data;
  logic [1:0]   dbg_state;

  mux_pipe_n #(.WIDTH(64), .NUM_INPUTS(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel_err(out_sel_err), .out_valid(out_valid), .out_ready(out_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- N=3 instance for out-of-range selects ----------------
  logic [191:0] d3_data;
  logic [1:0]   d3_sel, d3_state;
  logic         d3_valid, d3_in_ready, d3_out_valid, d3_err, d3_out_ready;
  logic [63:0]  d3_out;

  mux_pipe_n #(.WIDTH(64), .NUM_INPUTS(3)) dut3 (
    .clk(clk), .reset(reset), .in_data(d3_data), .in_sel(d3_sel),
    .in_valid(d3_valid), .in_ready(d3_in_ready), .out_data(d3_out),
    .out_sel_err(d3_err), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .dbg_state(d3_state)
  );

  // ---------------- sweep instances (WIDTH=32, N=2 and N=16) ----------------
  logic [63:0]  d2_data;
  logic [0:0]   d2_sel;
  logic [1:0]   d2_state;
  logic         d2_valid, d2_in_ready, d2_out_valid, d2_err, d2_out_ready;
  logic [31:0]  d2_out;

  mux_pipe_n #(.WIDTH(32), .NUM_INPUTS(2)) dut2 (
    .clk(clk), .reset(reset), .in_data(d2_data), .in_sel(d2_sel),
    .in_valid(d2_valid), .in_ready(d2_in_ready), .out_data(d2_out),
    .out_sel_err(d2_err), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .dbg_state(d2_state)
  );

  logic [511:0] d16_data;
  logic [3:0]   d16_sel;
  logic [1:0]   d16_state;
  logic         d16_valid, d16_in_ready, d16_out_valid, d16_err, d16_out_ready;
  logic [31:0]  d16_out;

  mux_pipe_n #(.WIDTH(32), .NUM_INPUTS(16)) dut16 (
    .clk(clk), .reset(reset), .in_data(d16_data), .in_sel(d16_sel),
    .in_valid(d16_valid), .in_ready(d16_in_ready), .out_data(d16_out),
    .out_sel_err(d16_err), .out_valid(d16_out_valid), .out_ready(d16_out_ready),
    .dbg_state(d16_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int emitted   = 0;
  logic [64:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Sweep input pattern: input k carries a value unique to k.
  function automatic logic [31:0] sweep_val(input int k);
    return 32'hA500_0000 + 32'(k) * 32'h0001_0011;
  endfunction

  // ---------------- behavioural model + compare (main DUT) ----------------
  // The block behaves as a FIFO of at most two selected beats. out_valid means
  // the FIFO is non-empty, in_ready means it is not full, and out shows the head.
  initial begin
    logic [64:0] held;
    logic        stall_prev;
    logic        acc;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        check("model_out_valid", {127'b0, out_valid}, {127'b0, exp_q.size() > 0});
        check("model_in_ready",  {127'b0, in_ready},  {127'b0, exp_q.size() < 2});
        if (exp_q.size() > 0)
          check("model_payload", {63'b0, out_sel_err, out_data}, {63'b0, exp_q[0]});
        if (stall_prev && out_valid)
          check("hold_stable", {63'b0, out_sel_err, out_data}, {63'b0, held});
        stall_prev = out_valid && !out_ready;
        held       = {out_sel_err, out_data};
        acc = in_valid && (exp_q.size() < 2);
        if (out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          emitted++;
        end
        if (acc) exp_q.push_back({1'b0, in_data[int'(in_sel)*64 +: 64]});
      end
    end
  end

  // ---------------- global time limit ----------------
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached, checks %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "time limit");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int sent;
    int cyc;
    int emitted_before;

    reset = 1'b1;
    in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b0;
    d3_data = '0; d3_sel = '0; d3_valid = 1'b0; d3_out_ready = 1'b1;
    d2_data = '0; d2_sel = '0; d2_valid = 1'b0; d2_out_ready = 1'b1;
    d16_data = '0; d16_sel = '0; d16_valid = 1'b0; d16_out_ready = 1'b1;

    // Reset values.
    #2;
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_in_ready",  {127'b0, in_ready},  128'd1);
    check("rst_out_data",  {64'b0, out_data},   128'd0);
    check("rst_sel_err",   {127'b0, out_sel_err}, 128'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset.
    @(posedge clk); #2;
    check("idle_out_valid", {127'b0, out_valid}, 128'd0);
    check("idle_in_ready",  {127'b0, in_ready},  128'd1);

    // Streaming with sel=2, out_ready=1.
    in_data = {64'h44, 64'h33, 64'h22, 64'h11};
    in_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      check("stream_valid",    {127'b0, out_valid}, 128'd1);
      check("stream_data",     {64'b0, out_data},   128'h33);
      check("stream_in_ready", {127'b0, in_ready},  128'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #2;
    check("stream_drained", {127'b0, out_valid}, 128'd0);

    // Backpressure: two beats fill main and skid.
    out_ready = 1'b0;
    in_data = {64'hBBBB, 64'h0, 64'h0, 64'hAAAA};
    in_sel = 2'd0; in_valid = 1'b1;
    @(posedge clk); #2;
    check("bp_first_data", {64'b0, out_data}, 128'hAAAA);
    check("bp_ready_one",  {127'b0, in_ready}, 128'd1);
    in_sel = 2'd3;
    @(posedge clk); #2;
    check("bp_state_two", {126'b0, dbg_state}, 128'd2);
    check("bp_in_ready",  {127'b0, in_ready},  128'd0);
    check("bp_hold_data", {64'b0, out_data},   128'hAAAA);
    in_sel = 2'd1; in_data = {4{64'hDEAD_BEEF}};
    @(posedge clk); #2;
    check("bp_ignore_data",  {64'b0, out_data},   128'hAAAA);
    check("bp_ignore_state", {126'b0, dbg_state}, 128'd2);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #2;
    check("bp_second_data", {64'b0, out_data},   128'hBBBB);
    check("bp_ready_back",  {127'b0, in_ready},  128'd1);
    @(posedge clk); #2;
    check("bp_empty", {127'b0, out_valid}, 128'd0);

    // Asynchronous reset with two beats buffered.
    out_ready = 1'b0;
    in_data = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
    in_sel = 2'd1; in_valid = 1'b1;
    @(posedge clk); #2;
    in_sel = 2'd2;
    @(posedge clk); #2;
    check("mr_state_two", {126'b0, dbg_state}, 128'd2);
    #1 reset = 1'b1;
    #1;
    check("mr_valid_drop", {127'b0, out_valid}, 128'd0);
    check("mr_in_ready",   {127'b0, in_ready},  128'd1);
    check("mr_out_data",   {64'b0, out_data},   128'd0);
    check("mr_state",      {126'b0, dbg_state}, 128'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("mr_no_old_beat", {127'b0, out_valid}, 128'd0);
    end

    // Out-of-range select on the N=3 instance.
    d3_data = {64'h303, 64'h202, 64'h101};
    d3_sel = 2'd3; d3_valid = 1'b1;
    @(posedge clk); #2;
    check("oor_valid", {127'b0, d3_out_valid}, 128'd1);
    check("oor_data",  {64'b0, d3_out},        128'd0);
    check("oor_err",   {127'b0, d3_err},       128'd1);
    d3_sel = 2'd1;
    @(posedge clk); #2;
    check("oor_next_data", {64'b0, d3_out},  128'h202);
    check("oor_next_err",  {127'b0, d3_err}, 128'd0);
    d3_valid = 1'b0;
    @(posedge clk); #2;
    check("oor_done", {127'b0, d3_out_valid}, 128'd0);

    // Parameter sweep: every index returns its own input.
    for (int k = 0; k < 16; k++) d16_data[k*32 +: 32] = sweep_val(k);
    for (int k = 0; k < 2; k++)  d2_data[k*32 +: 32]  = sweep_val(k);
    d2_valid = 1'b1; d16_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      d16_sel = 4'(k);
      d2_sel  = 1'(k % 2);
      @(posedge clk); #2;
      check("sweep16_data", {96'b0, d16_out}, {96'b0, sweep_val(k)});
      check("sweep16_err",  {127'b0, d16_err}, 128'd0);
      check("sweep2_data",  {96'b0, d2_out},  {96'b0, sweep_val(k % 2)});
      check("sweep2_valid", {127'b0, d2_out_valid}, 128'd1);
    end
    d2_valid = 1'b0; d16_valid = 1'b0;

    // Random valid/ready stress on the main instance.
    emitted_before = emitted;
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      for (int j = 0; j < 4; j++) in_data[j*64 +: 64] = {$urandom(), $urandom()};
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check("stress_sent", 128'(sent), 128'd10000);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("drain_valid",   {127'b0, out_valid}, 128'd0);
    check("drain_model",   128'(exp_q.size()), 128'd0);
    check("stress_emitted", 128'(emitted - emitted_before), 128'd10000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
